pic_bus_ctrl: RTL and testbench

PIC_BUS_CTRL -- requirements
Module: pic_bus_ctrl

---
 rtl/pic_pkg.sv | 40 ++++
 rtl/pic_sync_edge.sv | 70 +++++++
 rtl/pic_bus_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_pic_bus_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC bus controller: FSM states, command codes,
// read-select encodings and the command-byte bit positions.
package pic_pkg;

    typedef enum logic [2:0] {
        ST_UNINIT = 3'd0,
        ST_ICW2   = 3'd1,
        ST_ICW3   = 3'd2,
        ST_ICW4   = 3'd3,
        ST_READY  = 3'd4
    } pic_state_e;

    typedef enum logic [2:0] {
        CMD_NONE = 3'd0,
        CMD_ICW1 = 3'd1,
        CMD_ICW2 = 3'd2,
        CMD_ICW3 = 3'd3,
        CMD_ICW4 = 3'd4,
        CMD_OCW1 = 3'd5,
        CMD_OCW2 = 3'd6,
        CMD_OCW3 = 3'd7
    } pic_cmd_e;

    localparam logic [1:0] RSEL_IRR  = 2'b00;
    localparam logic [1:0] RSEL_ISR  = 2'b01;
    localparam logic [1:0] RSEL_IMR  = 2'b10;
    localparam logic [1:0] RSEL_POLL = 2'b11;

    localparam int BIT_D4 = 4;
    localparam int BIT_D3 = 3;
    localparam int BIT_D2 = 2;
    localparam int BIT_D1 = 1;
    localparam int BIT_D0 = 0;

    // OCW3 read-register select: RIS bit picks ISR over IRR.
    function automatic logic [1:0] rr_sel(input logic ris);
        return ris ? RSEL_ISR : RSEL_IRR;
    endfunction

endpackage

// File: rtl/pic_sync_edge.sv
// Synchroniser for one access-active signal plus an aligned payload, with rise/fall pulses.
// The input is ignored after reset until it has been seen inactive at least once.
module pic_sync_edge #(
    parameter int STAGES = 2,
    parameter int PW     = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          act_i,
    input  logic [PW-1:0] pay_i,
    output logic          act_o,
    output logic [PW-1:0] pay_o,
    output logic          rise_o,
    output logic          fall_o
);
    logic          armed_q;
    logic          act_in;
    logic          act_s;
    logic [PW-1:0] pay_s;
    logic          prev_q;

    assign act_in = act_i & armed_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed_q <= 1'b0;
        end else if (!act_i) begin
            armed_q <= 1'b1;
        end
    end

    generate
        if (STAGES == 0) begin : g_direct
            assign act_s = act_in;
            assign pay_s = pay_i;
        end else begin : g_sync
            logic [STAGES-1:0] act_sh_q;
            logic [PW-1:0]     pay_sh_q [STAGES];

            // Payload travels through the same number of flops so it stays aligned with act.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    act_sh_q <= '0;
                    for (int i = 0; i < STAGES; i++) pay_sh_q[i] <= '0;
                end else begin
                    act_sh_q[0] <= act_in;
                    pay_sh_q[0] <= pay_i;
                    for (int i = 1; i < STAGES; i++) begin
                        act_sh_q[i] <= act_sh_q[i-1];
                        pay_sh_q[i] <= pay_sh_q[i-1];
                    end
                end
            end

            assign act_s = act_sh_q[STAGES-1];
            assign pay_s = pay_sh_q[STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev_q <= 1'b0;
        else          prev_q <= act_s;
    end

    assign act_o  = act_s;
    assign pay_o  = pay_s;
    assign rise_o = act_s & ~prev_q;
    assign fall_o = ~act_s & prev_q;

endmodule

// File: rtl/pic_bus_ctrl.sv
// 8259-style CPU bus front end: synchronises strobes, commits writes on strobe release,
// decodes the ICW/OCW sequence and tracks the read target.
module pic_bus_ctrl
    import pic_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cs_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              a0,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] internal_bus,
    output logic              wr_icw1,
    output logic              wr_icw2,
    output logic              wr_icw3,
    output logic              wr_icw4,
    output logic              wr_ocw1,
    output logic              wr_ocw2,
    output logic              wr_ocw3,
    output logic              init_done,
    output logic              single_mode,
    output logic              ic4,
    output logic [1:0]        read_sel,
    output logic              rd_start,
    output logic              rd_end,
    output logic              proto_err,
    output logic [2:0]        dbg_state
);
    logic              wr_act, wr_rise, wr_fall;
    logic [DATA_W:0]   wr_pay;
    logic              rd_act, rd_rise, rd_fall;
    logic              rd_a0;

    pic_sync_edge #(.STAGES(SYNC_STAGES), .PW(DATA_W + 1)) u_wr_sync (
        .clk(clk), .reset_n(reset_n), .act_i(!cs_n && !wr_n), .pay_i({a0, data_in}),
        .act_o(wr_act), .pay_o(wr_pay), .rise_o(wr_rise), .fall_o(wr_fall)
    );

    pic_sync_edge #(.STAGES(SYNC_STAGES), .PW(1)) u_rd_sync (
        .clk(clk), .reset_n(reset_n), .act_i(!cs_n && !rd_n), .pay_i(a0),
        .act_o(rd_act), .pay_o(rd_a0), .rise_o(rd_rise), .fall_o(rd_fall)
    );

    pic_state_e        state_q, state_d;
    pic_cmd_e          cmd_q, cmd_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] bus_q, bus_d;
    logic              init_q, init_d;
    logic              single_q, single_d;
    logic              ic4_q, ic4_d;
    logic [1:0]        rsel_q, rsel_d;
    logic [1:0]        base_q, base_d;
    logic              poll_q, poll_d;
    logic              rd_poll_q, rd_poll_d;
    logic              rd_live_q, rd_live_d;
    logic              rd_start_q, rd_start_d;
    logic              rd_end_q, rd_end_d;
    logic              wr_a0_q;
    logic [DATA_W-1:0] wr_data_q;

    // Last active cycle wins: the capture keeps overwriting while the write is active.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_a0_q   <= 1'b0;
            wr_data_q <= '0;
        end else if (wr_act) begin
            wr_a0_q   <= wr_pay[DATA_W];
            wr_data_q <= wr_pay[DATA_W-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = CMD_NONE;
        err_d      = 1'b0;
        bus_d      = bus_q;
        init_d     = init_q;
        single_d   = single_q;
        ic4_d      = ic4_q;
        rsel_d     = rsel_q;
        base_d     = base_q;
        poll_d     = poll_q;
        rd_poll_d  = rd_poll_q;
        rd_live_d  = rd_live_q;
        rd_start_d = 1'b0;
        rd_end_d   = 1'b0;

        // An overlap begins only when one strobe goes active while the other already is.
        if (wr_act && rd_act && (wr_rise || rd_rise)) err_d = 1'b1;

        if (rd_rise && !wr_act) begin
            rd_start_d = 1'b1;
            rd_live_d  = 1'b1;
            rd_poll_d  = poll_q;
            if (!poll_q && rd_a0) rsel_d = RSEL_IMR;
        end else if (rd_fall && rd_live_q) begin
            rd_end_d  = 1'b1;
            rd_live_d = 1'b0;
            if (rd_poll_q) poll_d = 1'b0;
            rsel_d = (poll_q && !rd_poll_q) ? RSEL_POLL : base_q;
        end

        if (wr_fall) begin
            bus_d = wr_data_q;
            if (!wr_a0_q && wr_data_q[BIT_D4]) begin
                cmd_d     = CMD_ICW1;
                single_d  = wr_data_q[BIT_D1];
                ic4_d     = wr_data_q[BIT_D0];
                init_d    = 1'b0;
                rsel_d    = RSEL_IRR;
                base_d    = RSEL_IRR;
                poll_d    = 1'b0;
                rd_poll_d = 1'b0;
                state_d   = ST_ICW2;
            end else begin
                unique case (state_q)
                    ST_UNINIT: err_d = 1'b1;
                    ST_ICW2: begin
                        if (wr_a0_q) begin
                            cmd_d = CMD_ICW2;
                            if (!single_q) begin
                                state_d = ST_ICW3;
                            end else if (ic4_q) begin
                                state_d = ST_ICW4;
                            end else begin
                                state_d = ST_READY;
                                init_d  = 1'b1;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    ST_ICW3: begin
                        if (wr_a0_q) begin
                            cmd_d = CMD_ICW3;
                            if (ic4_q) begin
                                state_d = ST_ICW4;
                            end else begin
                                state_d = ST_READY;
                                init_d  = 1'b1;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    ST_ICW4: begin
                        if (wr_a0_q) begin
                            cmd_d   = CMD_ICW4;
                            state_d = ST_READY;
                            init_d  = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    ST_READY: begin
                        if (wr_a0_q) begin
                            cmd_d = CMD_OCW1;
                        end else if (!wr_data_q[BIT_D3]) begin
                            cmd_d = CMD_OCW2;
                        end else begin
                            cmd_d = CMD_OCW3;
                            if (wr_data_q[BIT_D2]) begin
                                poll_d = 1'b1;
                                rsel_d = RSEL_POLL;
                            end else if (wr_data_q[BIT_D1]) begin
                                base_d = rr_sel(wr_data_q[BIT_D0]);
                                if (!poll_q) rsel_d = rr_sel(wr_data_q[BIT_D0]);
                            end
                        end
                    end
                    default: state_d = ST_UNINIT;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_UNINIT;
            cmd_q      <= CMD_NONE;
            err_q      <= 1'b0;
            bus_q      <= '0;
            init_q     <= 1'b0;
            single_q   <= 1'b0;
            ic4_q      <= 1'b0;
            rsel_q     <= RSEL_IRR;
            base_q     <= RSEL_IRR;
            poll_q     <= 1'b0;
            rd_poll_q  <= 1'b0;
            rd_live_q  <= 1'b0;
            rd_start_q <= 1'b0;
            rd_end_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            err_q      <= err_d;
            bus_q      <= bus_d;
            init_q     <= init_d;
            single_q   <= single_d;
            ic4_q      <= ic4_d;
            rsel_q     <= rsel_d;
            base_q     <= base_d;
            poll_q     <= poll_d;
            rd_poll_q  <= rd_poll_d;
            rd_live_q  <= rd_live_d;
            rd_start_q <= rd_start_d;
            rd_end_q   <= rd_end_d;
        end
    end

    assign wr_icw1      = (cmd_q == CMD_ICW1);
    assign wr_icw2      = (cmd_q == CMD_ICW2);
    assign wr_icw3      = (cmd_q == CMD_ICW3);
    assign wr_icw4      = (cmd_q == CMD_ICW4);
    assign wr_ocw1      = (cmd_q == CMD_OCW1);
    assign wr_ocw2      = (cmd_q == CMD_OCW2);
    assign wr_ocw3      = (cmd_q == CMD_OCW3);
    assign internal_bus = bus_q;
    assign init_done    = init_q;
    assign single_mode  = single_q;
    assign ic4          = ic4_q;
    assign read_sel     = rsel_q;
    assign rd_start     = rd_start_q;
    assign rd_end       = rd_end_q;
    assign proto_err    = err_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_pic_bus_ctrl.sv
// Bench for pic_bus_ctrl: directed command sequences plus randomized traffic scored
// against a command-sequence model of the 8259 bus protocol.
module tb_pic_bus_ctrl;
  import pic_pkg::*;

  localparam int C_NONE = 0, C_ICW1 = 1, C_ICW2 = 2, C_ICW3 = 3, C_ICW4 = 4;
  localparam int C_OCW1 = 5, C_OCW2 = 6, C_OCW3 = 7;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, a0 = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] internal_bus;
  logic       wr_icw1, wr_icw2, wr_icw3, wr_icw4, wr_ocw1, wr_ocw2, wr_ocw3;
  logic       init_done, single_mode, ic4, rd_start, rd_end, proto_err;
  logic [1:0] read_sel;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  pic_bus_ctrl #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a0(a0),
    .data_in(data_in), .internal_bus(internal_bus),
    .wr_icw1(wr_icw1), .wr_icw2(wr_icw2), .wr_icw3(wr_icw3), .wr_icw4(wr_icw4),
    .wr_ocw1(wr_ocw1), .wr_ocw2(wr_ocw2), .wr_ocw3(wr_ocw3),
    .init_done(init_done), .single_mode(single_mode), .ic4(ic4), .read_sel(read_sel),
    .rd_start(rd_start), .rd_end(rd_end), .proto_err(proto_err), .dbg_state(dbg_state)
  );

  // Extra instances with other synchroniser depths share the same stimulus.
  for (genvar g = 0; g < 2; g++) begin : g_aux
    localparam int S = (g == 0) ? 0 : 3;
    logic [7:0] bus;
    logic       p1, p2, p3, p4, ocw1, ocw2, ocw3, idone, smode, i4, rs, re, perr;
    logic [1:0] rsel;
    logic [2:0] st;
    pic_bus_ctrl #(.DATA_W(8), .SYNC_STAGES(S)) u (
      .clk(clk), .reset_n(reset_n), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a0(a0),
      .data_in(data_in), .internal_bus(bus),
      .wr_icw1(p1), .wr_icw2(p2), .wr_icw3(p3), .wr_icw4(p4),
      .wr_ocw1(ocw1), .wr_ocw2(ocw2), .wr_ocw3(ocw3),
      .init_done(idone), .single_mode(smode), .ic4(i4), .read_sel(rsel),
      .rd_start(rs), .rd_end(re), .proto_err(perr), .dbg_state(st)
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse monitor on the main instance: running totals, read as deltas by the tasks.
  int cmd_total = 0, err_total = 0, rs_total = 0, re_total = 0, multi_cnt = 0, last_cmd = 0;
  always @(posedge clk) begin
    int np;
    #1;
    np = int'(wr_icw1) + int'(wr_icw2) + int'(wr_icw3) + int'(wr_icw4) +
         int'(wr_ocw1) + int'(wr_ocw2) + int'(wr_ocw3);
    if (np > 1) multi_cnt++;
    if (np > 0) begin
      cmd_total += np;
      if (wr_icw1) last_cmd = C_ICW1;
      else if (wr_icw2) last_cmd = C_ICW2;
      else if (wr_icw3) last_cmd = C_ICW3;
      else if (wr_icw4) last_cmd = C_ICW4;
      else if (wr_ocw1) last_cmd = C_OCW1;
      else if (wr_ocw2) last_cmd = C_OCW2;
      else last_cmd = C_OCW3;
    end
    if (proto_err) err_total++;
    if (rd_start) rs_total++;
    if (rd_end) re_total++;
  end

  // Reference model: the remaining ICW words are a queue of expected commands.
  bit         m_active;
  int         m_seq[$];
  bit         m_init, m_single, m_ic4, m_poll;
  logic [1:0] m_base;
  logic [7:0] m_bus;

  function automatic logic [1:0] m_idle_sel();
    return m_poll ? 2'b11 : m_base;
  endfunction

  task automatic model_reset();
    m_active = 0; m_seq.delete(); m_init = 0; m_single = 0; m_ic4 = 0;
    m_poll = 0; m_base = 2'b00; m_bus = 8'h00;
  endtask

  task automatic model_write(input bit a0v, input logic [7:0] d, output int ec, output int ee);
    ec = C_NONE; ee = 0; m_bus = d;
    if (!a0v && d[4]) begin
      ec = C_ICW1; m_single = d[1]; m_ic4 = d[0]; m_init = 0; m_poll = 0; m_base = 2'b00;
      m_active = 1; m_seq.delete(); m_seq.push_back(C_ICW2);
      if (!d[1]) m_seq.push_back(C_ICW3);
      if (d[0]) m_seq.push_back(C_ICW4);
    end else if (!m_active) begin
      ee = 1;
    end else if (m_seq.size() > 0) begin
      if (a0v) begin
        ec = m_seq.pop_front();
        if (m_seq.size() == 0) m_init = 1;
      end else begin
        ee = 1;
      end
    end else if (a0v) begin
      ec = C_OCW1;
    end else if (!d[3]) begin
      ec = C_OCW2;
    end else begin
      ec = C_OCW3;
      if (d[2]) m_poll = 1;
      else if (d[1]) m_base = {1'b0, d[0]};
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " bus"}, internal_bus, m_bus);
    chk({tag, " init_done"}, init_done, m_init);
    chk({tag, " single"}, single_mode, m_single);
    chk({tag, " ic4"}, ic4, m_ic4);
    chk({tag, " read_sel"}, read_sel, m_idle_sel());
  endtask

  // Write access; data wanders during the active window and settles on d in the last cycle.
  task automatic do_write(input bit a0v, input logic [7:0] d, input bit with_rd, input string tag);
    int c0 = cmd_total, e0 = err_total, s0 = rs_total, r0 = re_total;
    int ec, ee, obs, n;
    model_write(a0v, d, ec, ee);
    if (with_rd) ee = ee + 1;
    @(posedge clk); #1;
    cs_n = 0; wr_n = 0; rd_n = !with_rd; a0 = a0v;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      data_in = 8'($urandom); @(posedge clk); #1;
    end
    data_in = d; @(posedge clk); #1;
    cs_n = 1; wr_n = 1; rd_n = 1; a0 = 1'($urandom); data_in = 8'($urandom);
    repeat (8) @(posedge clk); #1;
    obs = (cmd_total - c0 == 0) ? C_NONE : ((cmd_total - c0 == 1) ? last_cmd : 99);
    chk({tag, " cmd"}, obs, ec);
    chk({tag, " proto_err"}, err_total - e0, ee);
    if (with_rd) begin
      chk({tag, " rd_start"}, rs_total - s0, 0);
      chk({tag, " rd_end"}, re_total - r0, 0);
    end
    chk_idle(tag);
  endtask

  task automatic do_read(input bit a0v, input string tag);
    int s0 = rs_total, r0 = re_total;
    logic [1:0] exp_mid;
    exp_mid = m_poll ? 2'b11 : (a0v ? 2'b10 : m_base);
    @(posedge clk); #1;
    cs_n = 0; rd_n = 0; a0 = a0v;
    repeat (5) @(posedge clk); #1;
    chk({tag, " sel_during"}, read_sel, exp_mid);
    cs_n = 1; rd_n = 1; a0 = 1'($urandom);
    m_poll = 0;
    repeat (8) @(posedge clk); #1;
    chk({tag, " rd_start"}, rs_total - s0, 1);
    chk({tag, " rd_end"}, re_total - r0, 1);
    chk({tag, " sel_after"}, read_sel, m_idle_sel());
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
  task automatic do_reset(input string tag);
    @(posedge clk); #3;
    reset_n = 0; #1;
    model_reset();
    chk({tag, " state"}, dbg_state, ST_UNINIT);
    chk({tag, " pulses"}, int'(wr_icw1) + int'(wr_icw2) + int'(wr_icw3) + int'(wr_icw4) +
        int'(wr_ocw1) + int'(wr_ocw2) + int'(wr_ocw3) + int'(rd_start) + int'(rd_end) +
        int'(proto_err), 0);
    chk_idle(tag);
    repeat (2) @(posedge clk); #1;
    reset_n = 1;
  endtask

  task automatic lat_write(input logic [7:0] d);
    int ec, ee, l0 = -1, l2 = -1, l3 = -1;
    model_write(1, d, ec, ee);
    @(posedge clk); #1;
    cs_n = 0; wr_n = 0; a0 = 1; data_in = d;
    repeat (2) @(posedge clk); #1;
    cs_n = 1; wr_n = 1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (l0 < 0 && g_aux[0].ocw1) l0 = k;
      if (l2 < 0 && wr_ocw1) l2 = k;
      if (l3 < 0 && g_aux[1].ocw1) l3 = k;
    end
    chk("lat sync0", l0, 1);
    chk("lat sync2", l2, 3);
    chk("lat sync3", l3, 4);
    chk("lat sync3 bus", g_aux[1].bus, d);
    chk_idle("lat");
  endtask

  initial begin
    int c0, e0, r;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset("reset");

    // Single mode with ICW4: no ICW3 expected.
    do_write(0, 8'h13, 0, "icw1 single");
    do_write(1, 8'h20, 0, "icw2 single");
    do_write(1, 8'h01, 0, "icw4 single");

    // Cascade with ICW4, then an OCW1.
    do_write(0, 8'h11, 0, "icw1 cascade");
    do_write(1, 8'h20, 0, "icw2 cascade");
    do_write(1, 8'h04, 0, "icw3 cascade");
    do_write(1, 8'h01, 0, "icw4 cascade");
    do_write(1, 8'hFF, 0, "ocw1");
    do_write(0, 8'h20, 0, "ocw2");

    // Read register select, poll and the a0=1 mask read.
    do_write(0, 8'h0B, 0, "ocw3 rr isr");
    do_read(0, "read isr");
    do_write(0, 8'h0C, 0, "ocw3 poll");
    do_read(0, "read poll");
    do_read(1, "read imr");
    do_write(0, 8'h0A, 0, "ocw3 rr irr");
    do_read(0, "read irr");

    // Reset during a held write: the strobe must be released and re-asserted to commit.
    c0 = cmd_total; e0 = err_total;
    @(posedge clk); #1;
    cs_n = 0; wr_n = 0; a0 = 1; data_in = 8'h99;
    repeat (3) @(posedge clk); #1;
    reset_n = 0; model_reset();
    repeat (2) @(posedge clk); #1;
    reset_n = 1;
    repeat (3) @(posedge clk); #1;
    cs_n = 1; wr_n = 1;
    repeat (8) @(posedge clk); #1;
    chk("held write cmd", cmd_total - c0, 0);
    chk("held write err", err_total - e0, 0);
    chk_idle("held write");

    // UNINIT illegal write, then a simultaneous read/write.
    do_write(1, 8'h55, 0, "uninit write");
    do_write(1, 8'h66, 1, "collision");

    // Reset in the middle of the init sequence.
    do_write(0, 8'h11, 0, "icw1 pre-reset");
    do_write(1, 8'h20, 0, "icw2 pre-reset");
    do_reset("mid-seq reset");
    do_write(1, 8'h01, 0, "post-reset a0=1");

    // Strobe-to-pulse latency for synchroniser depths 0, 2, 3.
    do_write(0, 8'h12, 0, "icw1 lat");
    do_write(1, 8'h08, 0, "icw2 lat");
    lat_write(8'hA5);

    for (int k = 0; k < 50; k++) begin
      r = $urandom_range(0, 9);
      if (r < 5) do_write(1'($urandom_range(0, 1)), 8'($urandom), 0, "rnd write");
      else if (r < 7) do_write(0, 8'h08 | 8'($urandom_range(0, 7)), 0, "rnd ocw3");
      else if (r < 8) do_write(1'($urandom_range(0, 1)), 8'($urandom), 1, "rnd collision");
      else do_read(1'($urandom_range(0, 1)), "rnd read");
    end

    chk("one pulse per cycle", multi_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
